// File: rtl/launcher_pkg.sv
// Shared types and constants for the kernel launch sequencer.
package launcher_pkg;

  localparam int DCR_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRST,
    DCR,
    RUN,
    ABORT,
    REPORT
  } launch_state_t;

endpackage

// File: rtl/launch_cmd_fifo.sv
// Synchronous launch-command queue with count-based full/empty and show-ahead read data.
module launch_cmd_fifo
  import launcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DCR_DATA_BITS,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kernel_launcher.sv
// Host-side launch sequencer: pops queued launches, resets and programs the gpu,
// runs it under a watchdog and reports cycles/timeout per launch.
module kernel_launcher
  import launcher_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH   = 4,
  parameter int CYCLE_BITS       = 16,
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int GPU_RESET_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DCR_DATA_BITS-1:0] cmd_thread_count,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DCR_DATA_BITS-1:0] resp_thread_count,
  output logic [CYCLE_BITS-1:0]    resp_cycles,
  output logic                     resp_timeout,
  output logic                     gpu_reset,
  output logic                     gpu_start,
  input  logic                     gpu_done,
  output logic                     device_control_write_enable,
  output logic [DCR_DATA_BITS-1:0] device_control_data,
  output logic                     busy
);

  localparam int CW = $clog2(CMD_FIFO_DEPTH) + 1;
  localparam logic [CYCLE_BITS-1:0] GRST_LAST = CYCLE_BITS'(GPU_RESET_CYCLES - 1);
  localparam logic [CYCLE_BITS-1:0] TIMEOUT_LAST =
    CYCLE_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CYCLE_BITS-1:0] TIMEOUT_VAL = CYCLE_BITS'(TIMEOUT_CYCLES);
  localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES != 0);

  launch_state_t            state;
  launch_state_t            next_state;
  logic [CYCLE_BITS-1:0]    cycle_cnt;
  logic [CYCLE_BITS-1:0]    run_total;
  logic [DCR_DATA_BITS-1:0] tc;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            count_next;
  logic [DCR_DATA_BITS-1:0] fifo_data;
  logic                     push;
  logic                     pop;
  logic                     resp_load;
  logic [DCR_DATA_BITS-1:0] resp_tc_d;
  logic [CYCLE_BITS-1:0]    resp_cycles_d;
  logic                     resp_timeout_d;

  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  // RUN cycles including the current one, saturating at all-ones.
  assign run_total  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CYCLE_BITS'(1);

  launch_cmd_fifo #(
    .DEPTH (CMD_FIFO_DEPTH),
    .WIDTH (DCR_DATA_BITS)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cmd_thread_count),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    next_state     = state;
    pop            = 1'b0;
    resp_load      = 1'b0;
    resp_tc_d      = tc;
    resp_cycles_d  = '0;
    resp_timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (fifo_data == '0) begin
            next_state = REPORT;
            resp_load  = 1'b1;
            resp_tc_d  = fifo_data;
          end else begin
            next_state = GRST;
          end
        end
      end
      GRST: if (cycle_cnt == GRST_LAST) next_state = DCR;
      DCR:  next_state = RUN;
      RUN: begin
        if (gpu_done) begin
          next_state    = REPORT;
          resp_load     = 1'b1;
          resp_cycles_d = run_total;
        end else if (WATCHDOG_ON && cycle_cnt == TIMEOUT_LAST) begin
          next_state = ABORT;
        end
      end
      ABORT: begin
        if (cycle_cnt == GRST_LAST) begin
          next_state     = REPORT;
          resp_load      = 1'b1;
          resp_cycles_d  = TIMEOUT_VAL;
          resp_timeout_d = 1'b1;
        end
      end
      REPORT:  if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A single per-state cycle counter, cleared on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      tc        <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)   cycle_cnt <= '0;
      else if (cycle_cnt != '1)  cycle_cnt <= cycle_cnt + CYCLE_BITS'(1);
      if (pop) tc <= fifo_data;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpu_reset                   <= 1'b1;
      gpu_start                   <= 1'b0;
      device_control_write_enable <= 1'b0;
      device_control_data         <= '0;
      resp_valid                  <= 1'b0;
      resp_thread_count           <= '0;
      resp_cycles                 <= '0;
      resp_timeout                <= 1'b0;
      busy                        <= 1'b0;
    end else begin
      gpu_reset                   <= (next_state == GRST) || (next_state == ABORT);
      gpu_start                   <= (next_state == RUN);
      device_control_write_enable <= (next_state == DCR);
      device_control_data         <= (next_state == DCR) ? tc : '0;
      resp_valid                  <= (next_state == REPORT);
      busy                        <= (next_state != IDLE) || (count_next != '0);
      if (resp_load) begin
        resp_thread_count <= resp_tc_d;
        resp_cycles       <= resp_cycles_d;
        resp_timeout      <= resp_timeout_d;
      end
    end
  end

endmodule

// File: tb/tb_kernel_launcher.sv
// Randomized self-checking bench for kernel_launcher with a behavioural gpu and launch-level reference model.
module tb_kernel_launcher;

  localparam int TIMEOUT = 50;
  localparam int GRST    = 2;
  localparam int NEVER   = 0;

  typedef struct {
    int tc;
    int cycles;
    int timeout;
    int resets;
    int starts;
    int dcrs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_thread_count;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_thread_count;
  logic [15:0] resp_cycles;
  logic        resp_timeout;
  logic        gpu_reset;
  logic        gpu_start;
  logic        gpu_done;
  logic        dcr_we;
  logic [7:0]  dcr_data;
  logic        busy;

  exp_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 1;
  int   rst_cyc = 0;
  int   start_cyc = 0;
  int   dcr_cnt = 0;
  int   dcr_last = 0;
  int   dcr_bad = 0;

  kernel_launcher #(
    .CMD_FIFO_DEPTH   (4),
    .CYCLE_BITS       (16),
    .TIMEOUT_CYCLES   (TIMEOUT),
    .GPU_RESET_CYCLES (GRST)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .cmd_valid                   (cmd_valid),
    .cmd_ready                   (cmd_ready),
    .cmd_thread_count            (cmd_thread_count),
    .resp_valid                  (resp_valid),
    .resp_ready                  (resp_ready),
    .resp_thread_count           (resp_thread_count),
    .resp_cycles                 (resp_cycles),
    .resp_timeout                (resp_timeout),
    .gpu_reset                   (gpu_reset),
    .gpu_start                   (gpu_start),
    .gpu_done                    (gpu_done),
    .device_control_write_enable (dcr_we),
    .device_control_data         (dcr_data),
    .busy                        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Launch-level expectation: what the host should see for one command.
  function automatic exp_t expectFor(input int tc, input int lat);
    exp_t e;
    e.tc = tc;
    if (tc == 0) begin
      e.cycles = 0; e.timeout = 0; e.resets = 0; e.starts = 0; e.dcrs = 0;
    end else if (lat != NEVER && lat <= TIMEOUT) begin
      e.cycles = lat; e.timeout = 0; e.resets = GRST; e.starts = lat; e.dcrs = 1;
    end else begin
      e.cycles = TIMEOUT; e.timeout = 1; e.resets = 2 * GRST; e.starts = TIMEOUT; e.dcrs = 1;
    end
    return e;
  endfunction

  task automatic applyStimulus(input int tc, input int lat);
    int waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_thread_count = 8'(tc);
    while (!cmd_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_accept_bound", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(expectFor(tc, lat));
    if (tc != 0) lat_q.push_back(lat);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) checkOutput("drain_bound", 0, 1);
  endtask

  // Behavioural gpu: done on the lat-th start-high cycle; random noise on done while start is low.
  initial begin
    int run_cyc = 0;
    int cur_lat = NEVER;
    gpu_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        run_cyc = 0;
        gpu_done = 1'b0;
      end else if (gpu_start) begin
        if (run_cyc == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : NEVER;
        run_cyc++;
        gpu_done = (cur_lat != NEVER) && (run_cyc == cur_lat);
      end else begin
        run_cyc = 0;
        gpu_done = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       resp_ready = 1'b0;
        1:       resp_ready = 1'b1;
        default: resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Per-launch activity counters are compared and cleared at each response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        rst_cyc = 0; start_cyc = 0; dcr_cnt = 0; dcr_last = 0; dcr_bad = 0;
      end else begin
        if (gpu_reset) rst_cyc++;
        if (gpu_start) start_cyc++;
        if (dcr_we) begin
          dcr_cnt++;
          dcr_last = int'(dcr_data);
        end else if (dcr_data != 8'd0) begin
          dcr_bad++;
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("resp_unexpected", 1, 0);
          end else begin
            checkOutput("resp_thread_count", resp_thread_count, exp_q[0].tc);
            checkOutput("resp_cycles", resp_cycles, exp_q[0].cycles);
            checkOutput("resp_timeout", resp_timeout, exp_q[0].timeout);
            if (resp_ready) begin
              checkOutput("gpu_reset_cycles", rst_cyc, exp_q[0].resets);
              checkOutput("gpu_start_cycles", start_cyc, exp_q[0].starts);
              checkOutput("dcr_writes", dcr_cnt, exp_q[0].dcrs);
              if (exp_q[0].dcrs != 0) checkOutput("dcr_data", dcr_last, exp_q[0].tc);
              checkOutput("dcr_data_idle", dcr_bad, 0);
              void'(exp_q.pop_front());
              rst_cyc = 0; start_cyc = 0; dcr_cnt = 0; dcr_last = 0; dcr_bad = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_time_limit: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int n;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_thread_count = 8'd0;
    ready_mode = 1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_gpu_reset", gpu_reset, 1);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_gpu_start", gpu_start, 0);
    checkOutput("rst_dcr_we", dcr_we, 0);
    checkOutput("rst_resp_cycles", resp_cycles, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_gpu_reset", gpu_reset, 0);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] basic launch tc=8, done after 20");
    applyStimulus(8, 20);
    waitIdle();

    $display("[TB] zero thread count");
    applyStimulus(0, NEVER);
    n = 0;
    while (!resp_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    checkOutput("zero_tc_latency_ok", n <= 2, 1);
    checkOutput("zero_tc_no_start", gpu_start, 0);
    waitIdle();

    $display("[TB] watchdog boundaries");
    applyStimulus(20, TIMEOUT);
    applyStimulus(21, TIMEOUT + 1);
    applyStimulus(22, NEVER);
    waitIdle();

    $display("[TB] queue full");
    ready_mode = 0;
    applyStimulus(9, 30);
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 4; i++) applyStimulus(i, 3);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_thread_count = 8'd5;
    for (int i = 0; i < 3; i++) begin
      checkOutput("cmd_ready_full", cmd_ready, 0);
      checkOutput("busy_full", busy, 1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    ready_mode = 1;
    applyStimulus(5, 3);
    waitIdle();

    $display("[TB] response backpressure");
    ready_mode = 0;
    applyStimulus(10, 5);
    applyStimulus(11, 7);
    repeat (25) @(negedge clk);
    checkOutput("stall_resp_valid", resp_valid, 1);
    checkOutput("stall_no_start", gpu_start, 0);
    checkOutput("stall_no_gpu_reset", gpu_reset, 0);
    checkOutput("stall_no_dcr", dcr_we, 0);
    ready_mode = 1;
    waitIdle();

    $display("[TB] reset during run");
    applyStimulus(3, NEVER);
    n = 0;
    while (!gpu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run_reached", gpu_start, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_gpu_start", gpu_start, 0);
    checkOutput("midrst_gpu_reset", gpu_reset, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_resp_valid", resp_valid, 0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postrst_resp_valid", resp_valid, 0);
    checkOutput("postrst_busy", busy, 0);
    checkOutput("postrst_gpu_reset", gpu_reset, 0);

    $display("[TB] randomized launches");
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      int tc;
      int lat;
      tc  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
      lat = ($urandom_range(0, 9) < 2) ? NEVER : int'($urandom_range(1, 60));
      applyStimulus(tc, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitIdle();
    ready_mode = 1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
